// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM peripheral and the SPI register block
// that feeds it.
package pwm_pkg;

    localparam int          PWM_CNT_W       = 8;
    localparam logic [7:0]  PWM_FULL        = 8'hFF;
    localparam int          DEFAULT_CLK_DIV = 13;

    // Register map, shared with the SPI register block
    localparam logic [6:0]  ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0]  ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0]  ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0]  ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0]  ADDR_PWM_DUTY    = 7'h04;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    // Full scale is forced high so that 0xFF really means 100 %.
    function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == PWM_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: tick is high one cycle in every CLK_DIV cycles.
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("pwm_prescaler: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM block: one shared prescaled 8-bit waveform, per-pin off/on/PWM
// select, duty double-buffered to the period boundary.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int NUM_OUT = 16;

    logic               tick;
    logic               wrap;
    logic               pwm_sig;
    pwm_cnt_t           pwm_cnt_q, pwm_cnt_d;
    pwm_cnt_t           duty_shadow_q, duty_shadow_d;
    logic               period_start_q, period_start_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [NUM_OUT-1:0] en_out, en_pwm;

    pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign wrap    = tick && (pwm_cnt_q == PWM_FULL);
    assign pwm_sig = pwm_level(pwm_cnt_q, duty_shadow_q);

    // Duty is sampled on the wrap edge itself, so a write landing on that
    // same edge already belongs to the new period.
    always_comb begin
        pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_shadow_d  = wrap ? pwm_duty_cycle : duty_shadow_q;
        period_start_d = wrap;
    end

    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
            assign out_d[i] = en_out[i] ? (en_pwm[i] ? pwm_sig : 1'b1) : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            duty_shadow_q  <= '0;
            period_start_q <= 1'b0;
            out_q          <= '0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at the default CLK_DIV of 13.
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int PER   = 256 * DEFAULT_CLK_DIV;
    localparam int BOUND = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        period_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Returns the number of negedges until period_start is seen high.
    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < BOUND);
        chk("ps_seen", 32'(period_start), 1);
    endtask

    // Counts consecutive negedge samples, starting with the current one, at
    // which out[b] equals lvl.
    task automatic run_len(input int b, input logic lvl, output int n);
        n = 0;
        while (out[b] === lvl && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, h, l, ones0, zeros0, zeros1;

        rst_n  = 1'b0;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'hFF;

        // Reset held with every input at full scale
        repeat (5) @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_ps", 32'(period_start), 0);

        // First period: shadow duty is 0, so PWM pins stay low
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("first_per_low", 32'(out), 0);
        wait_ps(n);
        chk("first_ps_clk", 32'(n + 100), PER);
        @(negedge clk);
        chk("full_duty_out", 32'(out), 32'h0000FFFF);

        // Static enables take effect one clock later
        en_out = 16'h0000;
        en_pwm = 16'h0000;
        @(negedge clk);
        chk("en_off", 32'(out), 0);
        en_out = 16'hFFFF;
        @(negedge clk);
        chk("en_static_on", 32'(out), 32'h0000FFFF);
        en_out = 16'h0000;
        @(negedge clk);
        chk("en_clear", 32'(out), 0);

        // 50 % duty on out[0]
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'h80;
        wait_ps(n);
        wait_ps(n);
        chk("d80_low_at_ps", 32'(out[0]), 0);
        @(negedge clk);
        chk("d80_rise_1clk", 32'(out[0]), 1);
        run_len(0, 1'b1, h);
        chk("d80_high", h, 1664);
        run_len(0, 1'b0, l);
        chk("d80_low", l, 1664);
        chk("d80_period", h + l, PER);

        // Duty 0 on out[0]; out[1] static on
        duty   = 8'h00;
        en_out = 16'h0003;
        wait_ps(n);
        ones0 = 0; zeros1 = 0;
        repeat (3 * PER) begin
            @(negedge clk);
            if (out[0]) ones0++;
            if (!out[1]) zeros1++;
        end
        chk("d00_ones", ones0, 0);
        chk("d00_static_zeros", zeros1, 0);

        // Duty 0xFF forced to a constant high
        duty = 8'hFF;
        wait_ps(n);
        @(negedge clk);
        zeros0 = 0; zeros1 = 0;
        repeat (3 * PER) begin
            if (!out[0]) zeros0++;
            if (!out[1]) zeros1++;
            @(negedge clk);
        end
        chk("dff_zeros", zeros0, 0);
        chk("dff_static_zeros", zeros1, 0);

        // Mid-period duty write is held off until the next wrap
        en_out = 16'h0001;
        duty   = 8'h40;
        wait_ps(n);
        @(negedge clk);
        h = 0;
        while (out[0] && h < BOUND) begin
            h++;
            if (h == 416) duty = 8'hC0;
            @(negedge clk);
        end
        chk("dbuf_cur_high", h, 832);
        wait_ps(n);
        @(negedge clk);
        run_len(0, 1'b1, h);
        chk("dbuf_next_high", h, 2496);

        // Write on the wrap edge lands in the new period
        wait_ps(n);
        repeat (PER - 1) @(negedge clk);
        duty = 8'h10;
        @(negedge clk);
        chk("wrapw_ps", 32'(period_start), 1);
        @(negedge clk);
        run_len(0, 1'b1, h);
        chk("wrapw_high", h, 208);

        // Asynchronous reset in the middle of a high phase
        duty = 8'h80;
        wait_ps(n);
        repeat (1045) @(negedge clk);
        chk("prerst_high", 32'(out[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 0);
        chk("async_rst_ps", 32'(period_start), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_len(0, 1'b0, l);
        chk("postrst_low", l, PER);
        run_len(0, 1'b1, h);
        chk("postrst_high", h, 1664);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
